// File: rtl/booth_iterative_multiplier.sv
// booth_iterative_multiplier: sequential radix-4 Booth multiplier for MULT/MULTU with start/busy/done handshake
// Ports:
//   Clk, Reset_n (async active-low)
//   Start, Sign, Flush, A, B                -> request, signedness, abort, operands
//   Busy, Done, Product                     -> in progress, one-cycle completion pulse, held 2*WIDTH result
// Optional: define MULT_ACCUM_EN to add the Accumulate input (Product <= Product + A*B, MADD/MADDU)
module booth_iterative_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic               Sign,
    input  logic               Flush,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
`ifdef MULT_ACCUM_EN
    input  logic               Accumulate,
`endif
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Product
);
    localparam int N_ITER = (WIDTH + 2) / 2;
    localparam int CW     = $clog2(N_ITER + 1);
    localparam int MW     = WIDTH + 2;
    localparam int PW     = WIDTH + 4;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [MW-1:0]      r_m, r_q;
    logic [PW-1:0]      r_p;
    logic               r_guard;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;
`ifdef MULT_ACCUM_EN
    logic               r_acc;
`endif

    logic               w_accept, w_finish, w_step;
    logic [MW-1:0]      w_a_ext, w_b_ext;
    logic [PW-1:0]      w_m_ext, w_mag, w_sum;
    logic [2:0]         w_sel;
    logic               w_zero, w_two, w_neg;
    logic [PW+MW:0]     w_shift;
    logic [2*WIDTH-1:0] w_prod;

    assign w_accept = (r_state == S_IDLE) && Start && !Flush;
    assign w_finish = (r_state == S_RUN) && (r_count == '0) && !Flush;
    assign w_step   = (r_state == S_RUN) && (r_count != '0);

    // The two extra operand bits make an unsigned WIDTH-bit value a positive signed one
    assign w_a_ext = {{2{Sign & A[WIDTH-1]}}, A};
    assign w_b_ext = {{2{Sign & B[WIDTH-1]}}, B};

    assign w_m_ext = {{2{r_m[MW-1]}}, r_m};
    assign w_sel   = {r_q[1:0], r_guard};
    assign w_zero  = (w_sel == 3'b000) || (w_sel == 3'b111);
    assign w_two   = (w_sel == 3'b011) || (w_sel == 3'b100);
    assign w_neg   = w_sel[2] && !w_zero;
    assign w_mag   = w_zero ? '0 : w_two ? {w_m_ext[PW-2:0], 1'b0} : w_m_ext;
    assign w_sum   = r_p + (w_neg ? ~w_mag : w_mag) + PW'(w_neg);

    // {P,Q,guard} arithmetic right shift by two; the dropped bits are Q[0] and the old guard
    assign w_shift = {{2{w_sum[PW-1]}}, w_sum, r_q[MW-1:1]};

    // After N_ITER shifts Q holds the low WIDTH+2 product bits, P the rest
    assign w_prod  = {r_p[WIDTH-3:0], r_q};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = Flush                ? S_IDLE :
                 (r_state == S_IDLE)  ? (Start ? S_RUN : S_IDLE) :
                 (r_state == S_RUN)   ? ((r_count == '0) ? S_DONE : S_RUN) :
                                        S_IDLE;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_m     <= '0;
            r_q     <= '0;
            r_p     <= '0;
            r_guard <= 1'b0;
            r_count <= '0;
`ifdef MULT_ACCUM_EN
            r_acc   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_m     <= w_a_ext;
            r_q     <= w_b_ext;
            r_p     <= '0;
            r_guard <= 1'b0;
            r_count <= CW'(N_ITER);
`ifdef MULT_ACCUM_EN
            r_acc   <= Accumulate;
`endif
        end else if (w_step) begin
            r_p     <= w_shift[PW+MW:MW+1];
            r_q     <= w_shift[MW:1];
            r_guard <= w_shift[0];
            r_count <= r_count - CW'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            r_product <= '0;
        else if (w_finish)
`ifdef MULT_ACCUM_EN
            r_product <= r_acc ? r_product + w_prod : w_prod;
`else
            r_product <= w_prod;
`endif
    end

    assign Busy    = (r_state != S_IDLE);
    assign Done    = (r_state == S_DONE);
    assign Product = r_product;
endmodule
